// File: rtl/relation_seq_ctrl.sv
// Frame sequencer: classifies consecutive 3-bit code pairs and keeps per-class saturating counts.
// Optional early abort on a NONE pair is enabled by defining RELSEQ_ABORT_EN.
module relation_seq_ctrl #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_code,
  output logic             class_valid,
  output logic [2:0]       class_code,
  output logic [CNT_W-1:0] more_cnt,
  output logic [CNT_W-1:0] less_cnt,
  output logic [CNT_W-1:0] ex3_cnt,
  output logic [CNT_W-1:0] gray_cnt,
  output logic [CNT_W-1:0] none_cnt,
  output logic [2:0]       last_code,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {IDLE, FIRST, RUN, DONE} state_t;

  localparam logic [2:0] CLS_NONE = 3'd0;
  localparam logic [2:0] CLS_MORE = 3'd1;
  localparam logic [2:0] CLS_LESS = 3'd2;
  localparam logic [2:0] CLS_EX3  = 3'd3;
  localparam logic [2:0] CLS_GRAY = 3'd4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  state_t     state, state_nxt;
  logic [7:0] sample_cnt;
  logic [3:0] a, b;
  logic [2:0] diff_bits;
  logic [2:0] cls;
  logic       abort_hit;
  logic       accept;
  logic       last_sample;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == CNT_MAX) ? x : x + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Zero-extended so the difference tests never wrap inside 3 bits.
  assign a         = {1'b0, in_code};
  assign b         = {1'b0, last_code};
  assign diff_bits = in_code ^ last_code;

  always_comb begin
    cls = CLS_NONE;
    if (a == b + 4'd1)
      cls = CLS_MORE;
    else if (b == a + 4'd1)
      cls = CLS_LESS;
    else if ((a == b + 4'd3) || (b == a + 4'd3))
      cls = CLS_EX3;
    else if ((diff_bits != 3'd0) && ((diff_bits & (diff_bits - 3'd1)) == 3'd0))
      cls = CLS_GRAY;
  end

`ifdef RELSEQ_ABORT_EN
  assign abort_hit = (cls == CLS_NONE);
`else
  assign abort_hit = 1'b0;
`endif

  assign accept      = in_valid && in_ready;
  assign last_sample = (sample_cnt == LAST_IDX);

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    in_ready  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = FIRST;
      end
      FIRST: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid && (last_sample || abort_hit)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sample_cnt  <= 8'd0;
      class_valid <= 1'b0;
      class_code  <= CLS_NONE;
      last_code   <= 3'd0;
      more_cnt    <= '0;
      less_cnt    <= '0;
      ex3_cnt     <= '0;
      gray_cnt    <= '0;
      none_cnt    <= '0;
      aborted     <= 1'b0;
    end else begin
      state       <= state_nxt;
      class_valid <= 1'b0;
      if (state == IDLE && start) begin
        sample_cnt <= 8'd0;
        more_cnt   <= '0;
        less_cnt   <= '0;
        ex3_cnt    <= '0;
        gray_cnt   <= '0;
        none_cnt   <= '0;
        aborted    <= 1'b0;
      end else if (state == FIRST && accept) begin
        last_code  <= in_code;
        sample_cnt <= 8'd1;
      end else if (state == RUN && accept) begin
        class_code  <= cls;
        class_valid <= 1'b1;
        last_code   <= in_code;
        sample_cnt  <= sample_cnt + 8'd1;
        case (cls)
          CLS_MORE: more_cnt <= sat_inc(more_cnt);
          CLS_LESS: less_cnt <= sat_inc(less_cnt);
          CLS_EX3:  ex3_cnt  <= sat_inc(ex3_cnt);
          CLS_GRAY: gray_cnt <= sat_inc(gray_cnt);
          default:  none_cnt <= sat_inc(none_cnt);
        endcase
        if (abort_hit) aborted <= 1'b1;
      end
    end
  end

endmodule
